// File: rtl/debug_pin_router.sv
// Routes selectable debug-vector bits to spare pins/LEDs, each pin running one of
// four modes: direct, pulse-stretch, toggle-on-rise or shared heartbeat.
module debug_pin_router #(
   parameter int unsigned NPIN     = 4,
   parameter int unsigned NSIG     = 16,
   parameter int unsigned STRETCH  = 1000000,
   parameter int unsigned HB_W     = 25,
   parameter logic [5:0]  CFG_ADDR = 6'h39
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [5:0]      cmd_addr,
   input  logic [31:0]     cmd_data,
   input  logic            cmd_rqst,
   input  logic [NSIG-1:0] dbg_in,
   output logic [NPIN-1:0] pin_out,
   output logic            cfg_err
);

   localparam int unsigned SW = (NSIG > 1) ? $clog2(NSIG) : 1;
   localparam int unsigned CW = $clog2(STRETCH + 1);

   typedef enum logic [1:0] {
      MODE_DIRECT  = 2'd0,
      MODE_STRETCH = 2'd1,
      MODE_TOGGLE  = 2'd2,
      MODE_HEART   = 2'd3
   } mode_e;

   // Reset asserts asynchronously but releases two clocks after rst_n rises.
   logic [1:0] rst_sync_q;
   logic       rst_ni;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= '0;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign rst_ni = rst_sync_q[1];

   logic [NSIG-1:0] sync1_q, s_q;

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= '0;
         s_q     <= '0;
      end else begin
         sync1_q <= dbg_in;
         s_q     <= sync1_q;
      end
   end

   logic          cfg_hit, pin_ok, src_ok, wr_ok;
   logic [7:0]    wr_pin;
   logic [SW-1:0] wr_src;
   mode_e         wr_mode;
   logic          unused_ok;

   assign cfg_hit   = cmd_rqst && (cmd_addr == CFG_ADDR);
   assign pin_ok    = 32'(cmd_data[31:24]) < NPIN;
   assign src_ok    = 32'(cmd_data[7:0]) < NSIG;
   assign wr_ok     = cfg_hit && pin_ok && src_ok;
   assign wr_pin    = cmd_data[31:24];
   assign wr_src    = cmd_data[SW-1:0];
   assign wr_mode   = mode_e'(cmd_data[9:8]);
   assign unused_ok = ^cmd_data[23:10];

   logic cfg_err_q;
   logic [HB_W-1:0] hb_q;

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         cfg_err_q <= 1'b0;
         hb_q      <= '0;
      end else begin
         cfg_err_q <= cfg_hit && !(pin_ok && src_ok);
         hb_q      <= hb_q + HB_W'(1);
      end
   end

   assign cfg_err = cfg_err_q;

   for (genvar p = 0; p < NPIN; p++) begin : g_pin
      mode_e         mode_q, mode_d;
      logic [SW-1:0] src_q, src_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          xprev_q, xprev_d;
      logic          tog_q, tog_d;
      logic          pin_q, pin_d;
      logic          wr_here, x, rise;

      assign wr_here = wr_ok && (wr_pin == 8'(p));

      always_comb begin
         x       = s_q[src_q];
         rise    = x & ~xprev_q;
         mode_d  = mode_q;
         src_d   = src_q;
         xprev_d = x;
         cnt_d   = cnt_q;
         tog_d   = tog_q;
         pin_d   = 1'b0;

         if (mode_q == MODE_STRETCH) begin
            if (rise)               cnt_d = CW'(STRETCH);
            else if (cnt_q != '0)   cnt_d = cnt_q - CW'(1);
         end
         if (mode_q == MODE_TOGGLE && rise) tog_d = ~tog_q;

         unique case (mode_q)
            MODE_DIRECT:  pin_d = x;
            MODE_STRETCH: pin_d = (cnt_q != '0);
            MODE_TOGGLE:  pin_d = tog_q;
            MODE_HEART:   pin_d = hb_q[HB_W-1];
         endcase

         // A write overrides any same-cycle rise and blanks the pin for one cycle.
         if (wr_here) begin
            mode_d  = wr_mode;
            src_d   = wr_src;
            xprev_d = s_q[wr_src];
            cnt_d   = '0;
            tog_d   = 1'b0;
            pin_d   = 1'b0;
         end
      end

      always_ff @(posedge clk or negedge rst_ni) begin
         if (!rst_ni) begin
            mode_q  <= MODE_DIRECT;
            src_q   <= SW'(p % NSIG);
            cnt_q   <= '0;
            xprev_q <= 1'b0;
            tog_q   <= 1'b0;
            pin_q   <= 1'b0;
         end else begin
            mode_q  <= mode_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            xprev_q <= xprev_d;
            tog_q   <= tog_d;
            pin_q   <= pin_d;
         end
      end

      assign pin_out[p] = pin_q;
   end

endmodule
